dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory (`dmem`) between the `mips` core's data port and a DMA/loader requester. Sits between both requesters and `dmem` in `top`: one access per cycle, round-robin on contention, bounded DMA bursts, registered read return. Also counts CPU stall cycles for performance debug.

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter bus bundle: CPU port, DMA port and dmem side.
// master = requesters + memory, slave = arbiter.
interface dmem_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic [DW-1:0] c_rdata;
  logic          c_rvalid;

  logic          d_req;
  logic          d_we;
  logic          d_lock;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic [DW-1:0] d_rdata;
  logic          d_rvalid;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rdata, c_rvalid,
    output d_req, d_we, d_lock, d_addr, d_wdata,
    input  d_gnt, d_rdata, d_rvalid,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rdata, c_rvalid,
    input  d_req, d_we, d_lock, d_addr, d_wdata,
    output d_gnt, d_rdata, d_rvalid,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares dmem between CPU and DMA: round-robin, bounded locked
// bursts, registered read return, saturating CPU stall counter.
module dmem_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  dmem_arbiter_if.slave    bus,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, CPU, DMA} owner_t;

  owner_t        owner, owner_nxt;
  logic          last_dma, last_dma_nxt;
  logic [BW-1:0] burst, burst_nxt;
  logic          c_gnt, d_gnt;
  logic          hold;
  logic          c_rd, d_rd;
  logic [DW-1:0] c_rdata_q, d_rdata_q;
  logic          c_rvalid_q, d_rvalid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner    <= IDLE;
      last_dma <= 1'b1;
      burst    <= '0;
    end else begin
      owner    <= owner_nxt;
      last_dma <= last_dma_nxt;
      burst    <= burst_nxt;
    end
  end

  assign hold = (owner == DMA) & bus.d_lock
              & (burst < BMAX);

  // grants are masked while reset is low
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset) begin
      unique case (1'b1)
        (bus.c_req & ~bus.d_req): c_gnt = 1'b1;
        (~bus.c_req & bus.d_req): d_gnt = 1'b1;
        (bus.c_req & bus.d_req): begin
          if (hold)          d_gnt = 1'b1;
          else if (last_dma) c_gnt = 1'b1;
          else               d_gnt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    owner_nxt    = IDLE;
    last_dma_nxt = last_dma;
    burst_nxt    = '0;
    if (c_gnt) begin
      owner_nxt    = CPU;
      last_dma_nxt = 1'b0;
    end else if (d_gnt) begin
      owner_nxt    = DMA;
      last_dma_nxt = 1'b1;
    end
    if (d_gnt & bus.d_lock)
      burst_nxt = (burst == BMAX) ? burst : burst + 1'b1;
  end

  assign c_rd = c_gnt & ~bus.c_we;
  assign d_rd = d_gnt & ~bus.d_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      c_rvalid_q <= c_rd;
      d_rvalid_q <= d_rd;
      if (c_rd) c_rdata_q <= bus.mem_rdata;
      if (d_rd) d_rdata_q <= bus.mem_rdata;
      if (bus.c_req & ~c_gnt & (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.c_gnt    = c_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.c_rdata  = c_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.c_rvalid = c_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;

  assign bus.mem_we = (c_gnt & bus.c_we)
                    | (d_gnt & bus.d_we);
  assign bus.mem_addr  = c_gnt ? bus.c_addr
                       : d_gnt ? bus.d_addr : '0;
  assign bus.mem_wdata = c_gnt ? bus.c_wdata
                       : d_gnt ? bus.d_wdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Random + directed bench for dmem_arbiter against a
// rule-level arbitration and memory model.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] stall_cnt;
  logic [3:0]  stall4;

  dmem_arbiter_if #(.DW(DW), .AW(AW)) bus ();
  dmem_arbiter_if #(.DW(DW), .AW(AW)) bus2 ();

  dmem_arbiter #(
    .DW(DW), .AW(AW), .MAX_BURST(MB), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .bus(bus.slave), .stall_cnt(stall_cnt)
  );

  dmem_arbiter #(
    .DW(DW), .AW(AW), .MAX_BURST(MB), .CNT_W(4)
  ) dut4 (
    .clk(clk), .reset(reset),
    .bus(bus2.slave), .stall_cnt(stall4)
  );

  always #5 clk = ~clk;

  logic [31:0] dmem [64];
  assign bus.mem_rdata = dmem[bus.mem_addr[7:2]];
  always @(posedge clk)
    if (bus.mem_we) dmem[bus.mem_addr[7:2]] = bus.mem_wdata;

  assign bus2.c_req     = bus.c_req;
  assign bus2.c_we      = bus.c_we;
  assign bus2.c_addr    = bus.c_addr;
  assign bus2.c_wdata   = bus.c_wdata;
  assign bus2.d_req     = bus.d_req;
  assign bus2.d_we      = bus.d_we;
  assign bus2.d_lock    = bus.d_lock;
  assign bus2.d_addr    = bus.d_addr;
  assign bus2.d_wdata   = bus.d_wdata;
  assign bus2.mem_rdata = dmem[bus2.mem_addr[7:2]];

  int n_tests = 0;
  int n_fail  = 0;

  int          own;
  bit          m_last_dma;
  int          m_burst, m_st, m_st4;
  bit          e_cg, e_dg, e_crv, e_drv;
  logic [31:0] e_crd, e_drd;
  logic [31:0] ref_mem [64];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    own = 0; m_last_dma = 1'b1; m_burst = 0;
    m_st = 0; m_st4 = 0;
    e_crv = 1'b0; e_drv = 1'b0;
    e_crd = '0; e_drd = '0;
  endfunction

  task automatic drive_c(bit req, bit we,
                         logic [5:0] idx,
                         logic [31:0] wd);
    bus.c_req   = req;
    bus.c_we    = we;
    bus.c_addr  = {24'h0, idx, 2'b00};
    bus.c_wdata = wd;
  endtask

  task automatic drive_d(bit req, bit we, bit lock,
                         logic [5:0] idx,
                         logic [31:0] wd);
    bus.d_req   = req;
    bus.d_we    = we;
    bus.d_lock  = lock;
    bus.d_addr  = {24'h0, idx, 2'b00};
    bus.d_wdata = wd;
  endtask

  task automatic idle();
    drive_c(1'b0, 1'b0, 6'd0, 32'h0);
    drive_d(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
  endtask

  // one cycle: inputs were just driven after a negedge
  task automatic step();
    bit          cr, dr, dl, ewe;
    logic [31:0] ea, ewd;
    logic [5:0]  ci, di;
    #1;
    cr = bus.c_req; dr = bus.d_req; dl = bus.d_lock;
    ci = bus.c_addr[7:2]; di = bus.d_addr[7:2];
    e_cg = 1'b0; e_dg = 1'b0;
    if (cr && !dr) e_cg = 1'b1;
    else if (dr && !cr) e_dg = 1'b1;
    else if (cr && dr) begin
      if (own == 2 && dl && m_burst < MB) e_dg = 1'b1;
      else if (m_last_dma) e_cg = 1'b1;
      else e_dg = 1'b1;
    end
    ewe = 1'b0; ea = '0; ewd = '0;
    if (e_cg) begin
      ewe = bus.c_we; ea = bus.c_addr; ewd = bus.c_wdata;
    end else if (e_dg) begin
      ewe = bus.d_we; ea = bus.d_addr; ewd = bus.d_wdata;
    end
    check("c_gnt", bus.c_gnt, e_cg);
    check("d_gnt", bus.d_gnt, e_dg);
    check("mem_we", bus.mem_we, ewe);
    check("mem_addr", bus.mem_addr, ea);
    check("mem_wdata", bus.mem_wdata, ewd);
    check("c_rvalid", bus.c_rvalid, e_crv);
    check("d_rvalid", bus.d_rvalid, e_drv);
    check("c_rdata", bus.c_rdata, e_crd);
    check("d_rdata", bus.d_rdata, e_drd);
    check("stall_cnt", stall_cnt, m_st);
    check("stall4", stall4, m_st4);
    e_crv = e_cg && !bus.c_we;
    e_drv = e_dg && !bus.d_we;
    if (e_crv) e_crd = ref_mem[ci];
    if (e_drv) e_drd = ref_mem[di];
    if (e_cg && bus.c_we) ref_mem[ci] = bus.c_wdata;
    if (e_dg && bus.d_we) ref_mem[di] = bus.d_wdata;
    if (cr && !e_cg) begin
      if (m_st < 65535) m_st++;
      if (m_st4 < 15) m_st4++;
    end
    own = e_cg ? 1 : (e_dg ? 2 : 0);
    if (e_cg || e_dg) m_last_dma = e_dg;
    if (e_dg && dl) m_burst = (m_burst < MB) ? m_burst + 1 : MB;
    else m_burst = 0;
  endtask

  // drop reset mid-cycle, release it after the next negedge
  task automatic apply_reset();
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("rst_c_gnt", bus.c_gnt, 0);
    check("rst_d_gnt", bus.d_gnt, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_c_rvalid", bus.c_rvalid, 0);
    check("rst_d_rvalid", bus.d_rvalid, 0);
    check("rst_c_rdata", bus.c_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_stall4", stall4, 0);
    idle();
    @(negedge clk);
    #1;
    check("rst_hold_d_rvalid", bus.d_rvalid, 0);
    check("rst_hold_c_rvalid", bus.c_rvalid, 0);
    reset = 1'b1;
    step();
  endtask

  task automatic fresh();
    @(negedge clk);
    idle();
    step();
    apply_reset();
  endtask

  initial begin
    logic [5:0]  pat;
    int          cnt;
    bit          cp, dp, cwe, dwe;
    logic [5:0]  ci, di;
    logic [31:0] cw, dw;

    reset = 1'b1;
    idle();
    for (int i = 0; i < 64; i++) begin
      dmem[i] = $urandom;
      ref_mem[i] = dmem[i];
    end
    model_reset();
    #1 reset = 1'b0;
    #2;
    check("por_c_gnt", bus.c_gnt, 0);
    check("por_stall", stall_cnt, 0);
    check("por_d_rvalid", bus.d_rvalid, 0);
    @(negedge clk);
    reset = 1'b1;

    // solo CPU write then read of 0x40
    @(negedge clk);
    drive_c(1'b1, 1'b1, 6'd16, 32'hDEADBEEF);
    step();
    check("solo_wr_gnt", bus.c_gnt, 1);
    @(negedge clk);
    drive_c(1'b1, 1'b0, 6'd16, 32'h0);
    step();
    check("solo_rd_gnt", bus.c_gnt, 1);
    @(negedge clk);
    idle();
    step();
    check("solo_rvalid", bus.c_rvalid, 1);
    check("solo_rdata", bus.c_rdata, 32'hDEADBEEF);
    check("solo_stall", stall_cnt, 0);
    @(negedge clk);
    step();
    check("solo_rvalid_end", bus.c_rvalid, 0);

    // tie without lock
    fresh();
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_c(1'b1, 1'b0, 6'(i), 32'h0);
      drive_d(1'b1, 1'b0, 1'b0, 6'(i + 8), 32'h0);
      step();
      pat = {pat[4:0], bus.d_gnt};
    end
    @(negedge clk);
    idle();
    step();
    check("tie_pattern", pat, 6'b010101);
    check("tie_stall", stall_cnt, 3);

    // locked burst while CPU waits
    fresh();
    @(negedge clk);
    drive_d(1'b1, 1'b0, 1'b0, 6'd3, 32'h0);
    step();
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_c(1'b1, 1'b0, 6'd1, 32'h0);
      drive_d(1'b1, 1'b1, 1'b1, 6'(40 + i), $urandom);
      step();
      pat = {pat[4:0], bus.d_gnt};
    end
    check("burst_pattern", pat, 6'b111101);
    check("burst_stall", stall_cnt, 4);

    // burst saturation with CPU idle
    fresh();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_d(1'b1, 1'b0, 1'b1, 6'(i), 32'h0);
      step();
      cnt += int'(bus.d_gnt);
    end
    check("sat_dma_grants", cnt, 10);
    @(negedge clk);
    drive_c(1'b1, 1'b0, 6'd2, 32'h0);
    drive_d(1'b1, 1'b0, 1'b1, 6'd9, 32'h0);
    step();
    check("sat_burst_hold", dut.burst, 4);
    check("sat_cpu_gnt", bus.c_gnt, 1);

    // async reset during a DMA read
    fresh();
    @(negedge clk);
    drive_d(1'b1, 1'b0, 1'b0, 6'd5, 32'h0);
    step();
    check("mid_rd_gnt", bus.d_gnt, 1);
    apply_reset();
    @(negedge clk);
    drive_c(1'b1, 1'b0, 6'd7, 32'h0);
    drive_d(1'b1, 1'b0, 1'b0, 6'd8, 32'h0);
    step();
    check("post_rst_tie_cpu", bus.c_gnt, 1);

    // stall counter saturation on the narrow instance
    fresh();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive_c(1'b1, 1'b0, 6'd11, 32'h0);
      drive_d(1'b1, 1'b0, 1'b0, 6'd12, 32'h0);
      step();
    end
    @(negedge clk);
    idle();
    step();
    check("stall4_sat", stall4, 15);
    check("stall16_cnt", stall_cnt, 20);

    // randomized traffic
    fresh();
    cp = 1'b0; dp = 1'b0;
    cwe = 1'b0; dwe = 1'b0;
    ci = '0; di = '0; cw = '0; dw = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!cp && $urandom_range(3) != 0) begin
        cp = 1'b1;
        cwe = 1'($urandom_range(1));
        ci = 6'($urandom_range(63));
        cw = $urandom;
      end
      if (!dp && $urandom_range(3) != 0) begin
        dp = 1'b1;
        dwe = 1'($urandom_range(1));
        di = 6'($urandom_range(63));
        dw = $urandom;
      end
      drive_c(cp, cwe, ci, cw);
      drive_d(dp, dwe, 1'($urandom_range(1)), di, dw);
      step();
      if (e_cg) cp = 1'b0;
      if (e_dg) dp = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
